// File: rtl/prf_free_list_pkg.sv
// Shared core constants and types for the rename, ROB and RS blocks.
// Carries the physical and architectural register counts and the tag type.
package prf_free_list_pkg;

    localparam int N_PREG   = 16;
    localparam int N_AREG   = 8;
    localparam int TAG_W    = $clog2(N_PREG);
    localparam int FL_DEPTH = N_PREG - N_AREG;

    typedef logic [TAG_W-1:0] tag_t;

    // Tag that free-list slot `slot` holds coming out of reset.
    function automatic tag_t reset_tag(input int slot);
        return tag_t'(N_AREG + slot);
    endfunction

endpackage

// File: rtl/prf_busy_table.sv
// Per-tag busy scoreboard: allocation sets a bit, result broadcasts clear it.
// A set and a clear of the same tag in one cycle leave the bit set.
module prf_busy_table #(
    parameter int N_PREG = prf_free_list_pkg::N_PREG,
    parameter int TAG_W  = $clog2(N_PREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [TAG_W-1:0]  set_tag,
    input  logic              clr0_en,
    input  logic [TAG_W-1:0]  clr0_tag,
    input  logic              clr1_en,
    input  logic [TAG_W-1:0]  clr1_tag,
    output logic [N_PREG-1:0] busy_vec
);

    logic [N_PREG-1:0] busy_next;

    // NOTE: busy_next takes the current vector as its default before any
    // conditional update, so every path assigns it and no latch is inferred.
    always_comb begin
        busy_next = busy_vec;
        for (int i = 0; i < N_PREG; i++) begin
            if ((clr0_en && clr0_tag == TAG_W'(i)) || (clr1_en && clr1_tag == TAG_W'(i)))
                busy_next[i] = 1'b0;
            if (set_en && set_tag == TAG_W'(i))
                busy_next[i] = 1'b1;
        end
    end

    // NOTE: registered state is written with <= only, so every flop samples
    // values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_next;
    end

endmodule

// File: rtl/prf_free_list.sv
// Physical-register free list: circular FIFO of free tags handed out at rename
// and refilled at commit, plus the busy scoreboard and a sticky overflow flag.
module prf_free_list #(
    parameter int N_PREG = prf_free_list_pkg::N_PREG,
    parameter int N_AREG = prf_free_list_pkg::N_AREG,
    parameter int TAG_W  = $clog2(N_PREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    output logic [TAG_W-1:0]  tag_PRF,
    output logic              full_PRF,
    input  logic              release_en,
    input  logic [TAG_W-1:0]  tag_Rw_old,
    input  logic              valid_Result_add,
    input  logic [TAG_W-1:0]  tag_PRF_add,
    input  logic              valid_Result_mul,
    input  logic [TAG_W-1:0]  tag_PRF_mul,
    output logic [N_PREG-1:0] busy_vec,
    output logic [TAG_W:0]    free_count,
    output logic              overflow_err
);

    localparam int             DEPTH   = N_PREG - N_AREG;
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [TAG_W:0] COUNT_D = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0] slots [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [TAG_W:0]   count;
    logic             do_alloc;
    logic             do_release;

    assign tag_PRF    = slots[head];
    assign full_PRF   = (count == '0);
    assign free_count = count;
    assign do_alloc   = alloc_en && !full_PRF;
    // Capacity is judged after this cycle's alloc, so a full list still
    // accepts a release when a tag leaves in the same cycle.
    assign do_release = release_en && (count != COUNT_D || do_alloc);

    // NOTE: the slot array is reset because the initial free tags are
    // architecturally defined; an uninitialised RAM would hand out garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= COUNT_D;
            overflow_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                slots[i] <= TAG_W'(N_AREG + i);
        end else begin
            if (do_alloc)
                head <= head + PTR_W'(1);
            if (do_release) begin
                slots[tail] <= tag_Rw_old;
                tail        <= tail + PTR_W'(1);
            end
            if (do_alloc && !do_release)
                count <= count - (TAG_W + 1)'(1);
            else if (do_release && !do_alloc)
                count <= count + (TAG_W + 1)'(1);
            if (release_en && !do_release)
                overflow_err <= 1'b1;
        end
    end

    prf_busy_table #(
        .N_PREG (N_PREG),
        .TAG_W  (TAG_W)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .set_en   (do_alloc),
        .set_tag  (tag_PRF),
        .clr0_en  (valid_Result_add),
        .clr0_tag (tag_PRF_add),
        .clr1_en  (valid_Result_mul),
        .clr1_tag (tag_PRF_mul),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list: directed scenarios plus a randomized
// run against a queue-based model of the free list and busy scoreboard.
module tb_prf_free_list;

    localparam int N_PREG = 16;
    localparam int N_AREG = 8;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = N_PREG - N_AREG;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_en;
    logic [TAG_W-1:0]  tag_PRF;
    logic              full_PRF;
    logic              release_en;
    logic [TAG_W-1:0]  tag_Rw_old;
    logic              valid_Result_add;
    logic [TAG_W-1:0]  tag_PRF_add;
    logic              valid_Result_mul;
    logic [TAG_W-1:0]  tag_PRF_mul;
    logic [N_PREG-1:0] busy_vec;
    logic [TAG_W:0]    free_count;
    logic              overflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model: free tags as a plain queue, busy bits as an array.
    int              m_q[$];
    bit [N_PREG-1:0] m_busy;
    bit              m_ovf;

    always #5 clk = ~clk;

    prf_free_list #(.N_PREG(N_PREG), .N_AREG(N_AREG), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_en         (alloc_en),
        .tag_PRF          (tag_PRF),
        .full_PRF         (full_PRF),
        .release_en       (release_en),
        .tag_Rw_old       (tag_Rw_old),
        .valid_Result_add (valid_Result_add),
        .tag_PRF_add      (tag_PRF_add),
        .valid_Result_mul (valid_Result_mul),
        .tag_PRF_mul      (tag_PRF_mul),
        .busy_vec         (busy_vec),
        .free_count       (free_count),
        .overflow_err     (overflow_err)
    );

    task automatic model_step();
        int  a_tag;
        bit  took;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < DEPTH; i++) m_q.push_back(N_AREG + i);
            m_busy = '0;
            m_ovf  = 1'b0;
        end else begin
            took  = alloc_en && (m_q.size() != 0);
            a_tag = 0;
            if (took) a_tag = m_q.pop_front();
            if (release_en) begin
                if (m_q.size() < DEPTH) m_q.push_back(int'(tag_Rw_old));
                else                    m_ovf = 1'b1;
            end
            if (valid_Result_add) m_busy[tag_PRF_add] = 1'b0;
            if (valid_Result_mul) m_busy[tag_PRF_mul] = 1'b0;
            if (took)             m_busy[a_tag] = 1'b1;
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; alloc_en = 1'b0; release_en = 1'b0; tag_Rw_old = '0;
        valid_Result_add = 1'b0; tag_PRF_add = '0;
        valid_Result_mul = 1'b0; tag_PRF_mul = '0;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tag_PRF !== 4'd8) begin errors++; $display("FAIL reset_tag got %0d want 8", tag_PRF); end
        checks++; if (full_PRF !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_PRF); end
        checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL reset_count got %0d want 8", free_count); end
        checks++; if (busy_vec !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h want 0000", busy_vec); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
    endtask

    task automatic test_alloc_to_empty();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (tag_PRF !== TAG_W'(N_AREG + i)) begin
                errors++; $display("FAIL alloc_seq[%0d] got %0d want %0d", i, tag_PRF, N_AREG + i);
            end
            alloc_en = 1'b1;
            cycle();
        end
        alloc_en = 1'b0;
        checks++; if (full_PRF !== 1'b1) begin errors++; $display("FAIL empty_full got %b want 1", full_PRF); end
        checks++; if (free_count !== 5'd0) begin errors++; $display("FAIL empty_count got %0d want 0", free_count); end
        checks++; if (busy_vec !== 16'hFF00) begin errors++; $display("FAIL empty_busy got %h want ff00", busy_vec); end
    endtask

    // Runs straight after test_alloc_to_empty, with the list empty.
    task automatic test_empty_alloc_release();
        alloc_en = 1'b1; release_en = 1'b1; tag_Rw_old = 4'd3;
        cycle();
        idle_inputs();
        checks++; if (tag_PRF !== 4'd3) begin errors++; $display("FAIL empty_rel_tag got %0d want 3", tag_PRF); end
        checks++; if (full_PRF !== 1'b0) begin errors++; $display("FAIL empty_rel_full got %b want 0", full_PRF); end
        checks++; if (free_count !== 5'd1) begin errors++; $display("FAIL empty_rel_count got %0d want 1", free_count); end
        checks++; if (busy_vec !== 16'hFF00) begin errors++; $display("FAIL empty_rel_busy got %h want ff00", busy_vec); end
    endtask

    task automatic test_steady_state();
        int exp_tag;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            exp_tag = (i < DEPTH) ? N_AREG + i : (i - DEPTH) % DEPTH;
            checks++;
            if (tag_PRF !== TAG_W'(exp_tag)) begin
                errors++; $display("FAIL steady_tag[%0d] got %0d want %0d", i, tag_PRF, exp_tag);
            end
            alloc_en = 1'b1; release_en = 1'b1; tag_Rw_old = TAG_W'(i % DEPTH);
            cycle();
            checks++;
            if (free_count !== 5'd8 || overflow_err !== 1'b0) begin
                errors++; $display("FAIL steady_count[%0d] got %0d/%b want 8/0", i, free_count, overflow_err);
            end
        end
        idle_inputs();
    endtask

    task automatic test_broadcast();
        do_reset();
        alloc_en = 1'b1;
        cycle();
        alloc_en = 1'b0;
        checks++; if (busy_vec[8] !== 1'b1) begin errors++; $display("FAIL bc_set8 got %b want 1", busy_vec[8]); end
        valid_Result_add = 1'b1; tag_PRF_add = 4'd8;
        valid_Result_mul = 1'b1; tag_PRF_mul = 4'd8;
        cycle();
        idle_inputs();
        checks++; if (busy_vec[8] !== 1'b0) begin errors++; $display("FAIL bc_clr8 got %b want 0", busy_vec[8]); end
        alloc_en = 1'b1; valid_Result_add = 1'b1; tag_PRF_add = 4'd9;
        cycle();
        idle_inputs();
        checks++; if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL bc_set_wins got %b want 1", busy_vec[9]); end
        checks++; if (busy_vec !== 16'h0200) begin errors++; $display("FAIL bc_vec got %h want 0200", busy_vec); end
    endtask

    task automatic test_overflow();
        do_reset();
        release_en = 1'b1; tag_Rw_old = 4'd2;
        cycle();
        idle_inputs();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_err); end
        checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", free_count); end
        cycle();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
        do_reset();
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_rst got %b want 0", overflow_err); end
        alloc_en = 1'b1; release_en = 1'b1; tag_Rw_old = 4'd5;
        cycle();
        idle_inputs();
        checks++;
        if (overflow_err !== 1'b0 || free_count !== 5'd8) begin
            errors++; $display("FAIL full_alloc_rel got %b/%0d want 0/8", overflow_err, free_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin alloc_en = 1'b1; cycle(); end
        idle_inputs();
        for (int i = 1; i <= 2; i++) begin release_en = 1'b1; tag_Rw_old = TAG_W'(i); cycle(); end
        rst = 1'b1; alloc_en = 1'b1; release_en = 1'b1; tag_Rw_old = 4'd7;
        valid_Result_add = 1'b1; tag_PRF_add = 4'd8;
        cycle();
        idle_inputs();
        checks++; if (tag_PRF !== 4'd8) begin errors++; $display("FAIL mid_rst_tag got %0d want 8", tag_PRF); end
        checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL mid_rst_count got %0d want 8", free_count); end
        checks++; if (busy_vec !== 16'h0000) begin errors++; $display("FAIL mid_rst_busy got %h want 0000", busy_vec); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            alloc_en         = ($urandom_range(0, 99) < 55);
            release_en       = ($urandom_range(0, 99) < 45);
            tag_Rw_old       = TAG_W'($urandom_range(0, N_PREG - 1));
            valid_Result_add = ($urandom_range(0, 99) < 40);
            tag_PRF_add      = TAG_W'($urandom_range(0, N_PREG - 1));
            valid_Result_mul = ($urandom_range(0, 99) < 40);
            tag_PRF_mul      = TAG_W'($urandom_range(0, N_PREG - 1));
            cycle();
            checks++;
            if (free_count !== (TAG_W + 1)'(m_q.size()) || full_PRF !== (m_q.size() == 0)) begin
                errors++; $display("FAIL rnd_count[%0d] got %0d/%b want %0d", i, free_count, full_PRF, m_q.size());
            end
            if (m_q.size() != 0) begin
                checks++;
                if (tag_PRF !== TAG_W'(m_q[0])) begin
                    errors++; $display("FAIL rnd_tag[%0d] got %0d want %0d", i, tag_PRF, m_q[0]);
                end
            end
            checks++;
            if (busy_vec !== m_busy) begin
                errors++; $display("FAIL rnd_busy[%0d] got %h want %h", i, busy_vec, m_busy);
            end
            checks++;
            if (overflow_err !== m_ovf) begin
                errors++; $display("FAIL rnd_ovf[%0d] got %b want %b", i, overflow_err, m_ovf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        test_reset();
        test_alloc_to_empty();
        test_empty_alloc_release();
        test_steady_state();
        test_broadcast();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_free_list.md
# prf_free_list

Physical-register tag allocator and busy scoreboard for the out-of-order core. At rename, it hands the front end the next free PRF tag (`tag_PRF`) and raises `full_PRF` when no free tag is left. At ROB commit, it takes back the superseded mapping (`tag_Rw_old`). It also tracks a per-tag busy bit: allocation sets it, and the add and mul result broadcasts clear it. It is the receiving end of the commit-release path and the broadcast path, and the producing end of the rename `tag_PRF`/`full_PRF` path.

## Interface
Parameters:
- `N_PREG`, 16: number of physical registers.
- `N_AREG`, 8: number of architectural registers. Tags 0..N_AREG-1 are mapped at reset.
- `TAG_W`, 4: tag width, equal to $clog2(N_PREG).

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `alloc_en`  in  1: rename consumes `tag_PRF` this cycle.
- `tag_PRF`  out  TAG_W: head free tag.
- `full_PRF`  out  1: no free tag available (count==0).
- `release_en`  in  1: commit returns a tag this cycle.
- `tag_Rw_old`  in  TAG_W: the tag being freed.
- `valid_Result_add`  in  1: add result broadcast valid.
- `tag_PRF_add`  in  TAG_W: add result broadcast tag.
- `valid_Result_mul`  in  1: mul result broadcast valid.
- `tag_PRF_mul`  in  TAG_W: mul result broadcast tag.
- `busy_vec`  out  N_PREG: bit i set means PRF[i] is awaiting its result.
- `free_count`  out  TAG_W+1: number of free tags.
- `overflow_err`  out  1: sticky flag, set by a release when the list is already at capacity.

## Operation
- Free list:
  - Circular FIFO of depth D = N_PREG-N_AREG.
  - Head/tail pointers are $clog2(D) bits and wrap naturally.
  - `count` is a separate register, range 0..D.
- Reset:
  - Slot i holds tag N_AREG+i.
  - head=0, tail=0, count=D.
  - `busy_vec`=0, `overflow_err`=0.
  - Resulting outputs: `tag_PRF`=8, `full_PRF`=0, `free_count`=8.
- Allocation:
  - Takes effect only if `alloc_en` && count!=0.
  - head advances by 1, count decrements.
  - Sets busy[tag_PRF].
  - `alloc_en` while `full_PRF` is ignored: no state change.
- Release:
  - If `release_en` && count!=D: write `tag_Rw_old` at tail, tail advances, count increments.
  - If `release_en` && count==D: drop the tag, set `overflow_err`.
- Simultaneous alloc and release:
  - Both take effect and count is unchanged.
  - When count==0, the alloc is ignored; the release still lands.
  - When count==D, the alloc takes effect and the release is accepted, because capacity is evaluated after the alloc.
- Broadcast:
  - Each valid broadcast clears busy of its tag.
  - Add and mul may clear two different tags, or the same tag, in one cycle.
  - If an allocation sets a tag while a broadcast clears the same tag in the same cycle, the set wins.
- Release does not touch busy bits. The tag was already cleared by its broadcast before commit.

## Timing
- `tag_PRF`, `full_PRF` and `free_count` are combinational from registered state. Rename sees them in the same cycle with zero latency.
- An allocated tag disappears from `tag_PRF` on the next cycle.
- A released tag can be allocated at the earliest one cycle after release, and only once it reaches head.
- `busy_vec` is registered. Set and clear become visible the cycle after the triggering edge.
- `rst` asserted mid-operation restores the reset state on the next edge. Pending inputs in that cycle are ignored.

## Structure
- Shared core package:
  - `TAG_W`, `N_PREG`, `N_AREG` constants.
  - `typedef logic [TAG_W-1:0] tag_t`.
  - The same package is reused by rename, ROB and RS.
- Sub-module `prf_busy_table`:
  - Inputs: one set port and two clear ports.
  - Output: `busy_vec`.
  - Implements the set-over-clear priority.
- FIFO, pointers and error flag live in `prf_free_list`.

## Test plan
- Reset, then 8 consecutive `alloc_en` → `tag_PRF` sequence 8,9,…,15. `full_PRF`=1 after the 8th, `free_count`=0, `busy_vec`=16'hFF00.
- With the list empty, drive `alloc_en`=1 and `release_en`=1 with `tag_Rw_old`=3 → alloc ignored. Next cycle `tag_PRF`=3, `full_PRF`=0, `free_count`=1.
- Steady-state alloc and release every cycle for 20 cycles → `free_count` constant. Tags leave in FIFO order, with pointer wrap past slot 7.
- Allocate tag 8. Next cycle, assert `valid_Result_add` and `valid_Result_mul` both with tag 8 → busy[8] goes 1→0. Separately, alloc tag 9 in the same cycle as a broadcast of 9 → busy[9]=1.
- From reset (count=8), release tag 2 → `overflow_err`=1 and sticky, `free_count` stays 8. `rst` clears the flag.
- Assert `rst` after 5 allocs and 2 releases → next cycle `tag_PRF`=8, `free_count`=8, `busy_vec`=0.
